// File: rtl/log_memory_ctrl_pkg.sv
// log_mem_pkg: state encoding and default geometry shared with the command register
package log_mem_pkg;
  localparam int DEF_NB_DATA = 32;
  localparam int DEF_NB_ADDR = 15;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_e;
endpackage

// File: rtl/log_memory_ctrl_bram.sv
// log_bram: simple dual-port RAM, one write port and a registered read-first read port
module log_bram #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we_i,
  input  logic [NB_ADDR-1:0] waddr_i,
  input  logic [NB_DATA-1:0] wdata_i,
  input  logic               re_i,
  input  logic [NB_ADDR-1:0] raddr_i,
  output logic [NB_DATA-1:0] rdata_o
);
  logic [NB_DATA-1:0] mem_q [2**NB_ADDR];
  logic [NB_DATA-1:0] rdata_q;
  always_ff @(posedge clock)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  // Only the output register is reset so the array still maps onto block RAM
  always_ff @(posedge clock)
    if (reset) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/log_memory_ctrl.sv
// log_memory_ctrl: captures a burst of datapath samples into RAM and serves readback to the micro
module log_memory_ctrl
  import log_mem_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_ADDR = DEF_NB_ADDR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_run_log,
  input  logic               i_read_log,
  input  logic [NB_ADDR-1:0] i_addr_log,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_mem_full,
  output logic               o_capturing,
  output logic [NB_DATA-1:0] o_data_log
);
  state_e             state_q;
  logic [NB_ADDR-1:0] wr_ptr_q;
  logic               wr_en;
  assign wr_en = (state_q == CAPTURE) && i_valid && !i_run_log;
  // Run restarts from any state and takes priority over a coincident sample
  always_ff @(posedge clock)
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
    end else if (i_run_log) begin
      state_q  <= CAPTURE;
      wr_ptr_q <= '0;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_q + NB_ADDR'(1);
      if (wr_ptr_q == '1) state_q <= FULL;
    end
  assign o_capturing = (state_q == CAPTURE);
  assign o_mem_full  = (state_q == FULL);
  log_bram #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR)
  ) u_bram (
    .clock  (clock),
    .reset  (reset),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(i_data),
    .re_i   (i_read_log),
    .raddr_i(i_addr_log),
    .rdata_o(o_data_log)
  );
endmodule

// File: tb/tb_log_memory_ctrl.sv
// tb_log_memory_ctrl: directed checks of capture, full, freeze, restart, reset abort and read-first
module tb_log_memory_ctrl;
  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 4;
  localparam int DEPTH   = 2**NB_ADDR;
  logic               clock = 1'b0;
  logic               reset;
  logic               i_run_log;
  logic               i_read_log;
  logic [NB_ADDR-1:0] i_addr_log;
  logic               i_valid;
  logic [NB_DATA-1:0] i_data;
  logic               o_mem_full;
  logic               o_capturing;
  logic [NB_DATA-1:0] o_data_log;
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  log_memory_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clock      (clock),
    .reset      (reset),
    .i_run_log  (i_run_log),
    .i_read_log (i_read_log),
    .i_addr_log (i_addr_log),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_mem_full (o_mem_full),
    .o_capturing(o_capturing),
    .o_data_log (o_data_log)
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [NB_DATA-1:0] obs, input logic [NB_DATA-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic read_chk(input string tag, input int a, input logic [NB_DATA-1:0] exp);
    i_read_log = 1'b1;
    i_addr_log = NB_ADDR'(a);
    tick();
    i_read_log = 1'b0;
    chk(tag, o_data_log, exp);
  endtask
  initial begin
    reset = 1'b1; i_run_log = 1'b0; i_read_log = 1'b0; i_addr_log = '0; i_valid = 1'b0; i_data = '0;
    tick();
    chk("rst_capturing", 32'(o_capturing), 32'd0);
    chk("rst_full", 32'(o_mem_full), 32'd0);
    chk("rst_data", o_data_log, 32'd0);
    reset = 1'b0;
    // 1: back-to-back fill
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0;
    chk("run_capturing", 32'(o_capturing), 32'd1);
    for (int n = 0; n < DEPTH; n++) begin
      i_valid = 1'b1;
      i_data  = 32'hA000 + n;
      tick();
      chk("fill_full", 32'(o_mem_full), (n == DEPTH-1) ? 32'd1 : 32'd0);
      chk("fill_capturing", 32'(o_capturing), (n == DEPTH-1) ? 32'd0 : 32'd1);
    end
    i_valid = 1'b0;
    // 2: readback sweep, then hold
    for (int a = 0; a < DEPTH; a++) read_chk("readback_a", a, 32'hA000 + a);
    i_addr_log = 4'd5;
    tick();
    chk("hold", o_data_log, 32'hA00F);
    // 3: FULL ignores writes; run discards a coincident sample
    i_valid = 1'b1; i_data = 32'hDEAD;
    repeat (5) tick();
    i_valid = 1'b0;
    chk("full_stays", 32'(o_mem_full), 32'd1);
    read_chk("frozen_a3", 3, 32'hA003);
    i_run_log = 1'b1; i_valid = 1'b1; i_data = 32'hBEEF;
    tick();
    i_run_log = 1'b0; i_valid = 1'b0;
    chk("restart_full", 32'(o_mem_full), 32'd0);
    chk("restart_capturing", 32'(o_capturing), 32'd1);
    read_chk("run_discard_a0", 0, 32'hA000);
    // 4: gapped strobes
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0;
    for (int n = 0; n < DEPTH; n++) begin
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("gap_full", 32'(o_mem_full), 32'd0);
      end
      i_valid = 1'b1;
      i_data  = 32'hB000 + n;
      tick();
      i_valid = 1'b0;
      chk("gapped_full", 32'(o_mem_full), (n == DEPTH-1) ? 32'd1 : 32'd0);
    end
    for (int a = 0; a < DEPTH; a++) read_chk("readback_b", a, 32'hB000 + a);
    // 5: reset mid-capture
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0;
    for (int n = 0; n < 7; n++) begin
      i_valid = 1'b1;
      i_data  = 32'hC000 + n;
      tick();
    end
    i_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_capturing", 32'(o_capturing), 32'd0);
    chk("abort_full", 32'(o_mem_full), 32'd0);
    chk("abort_data", o_data_log, 32'd0);
    i_valid = 1'b1; i_data = 32'hEEEE;
    repeat (3) tick();
    i_valid = 1'b0;
    for (int a = 0; a < DEPTH; a++) read_chk("after_abort", a, (a < 7) ? 32'hC000 + a : 32'hB000 + a);
    // 6: read-during-write returns old contents
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_data = 32'hD000 + k;
      i_read_log = 1'b1; i_addr_log = NB_ADDR'(k);
      tick();
      i_valid = 1'b0; i_read_log = 1'b0;
      chk("rdw_old", o_data_log, 32'hC000 + k);
      read_chk("rdw_new", k, 32'hD000 + k);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/log_memory_ctrl.md
Name: log_memory_ctrl

Overview:
- Capture-and-readback log memory behind the micro-facing command register.
- Consumes the run-log pulse, read-log strobe and read address from that register.
- Stores a burst of datapath samples into on-chip RAM and reports full.
- Returns the addressed word, which the register forwards to the micro.

Parameters:
NB_DATA, 32, width of one logged word (matches the micro data bus)
NB_ADDR, 15, address width; depth DEPTH = 2**NB_ADDR words

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
i_run_log  in  1  one-cycle pulse: restart capture from address 0
i_read_log  in  1  level: read port enabled
i_addr_log  in  NB_ADDR  read address
i_valid  in  1  sample strobe from datapath (one word per strobe)
i_data  in  NB_DATA  sample word
o_mem_full  out  1  capture complete, all DEPTH words written
o_capturing  out  1  FSM in CAPTURE
o_data_log  out  NB_DATA  read data to command register

Behaviour:
- Reset (reset=1 at a posedge) sets these values:
  - state=IDLE, wr_ptr=0, o_mem_full=0, o_capturing=0, o_data_log=0.
  - RAM contents are not cleared.
- The FSM has three states, IDLE, CAPTURE and FULL. State is registered; o_capturing and o_mem_full are decoded from it.
- i_run_log=1 in any state:
  - next state=CAPTURE, wr_ptr<=0.
  - o_mem_full deasserts the following cycle.
  - Any i_valid in that same cycle is discarded. Run has priority; no write occurs.
- In CAPTURE, each cycle with i_valid=1 and i_run_log=0:
  - RAM[wr_ptr]<=i_data, wr_ptr<=wr_ptr+1.
  - When the write lands at wr_ptr=DEPTH-1: state<=FULL, wr_ptr wraps to 0.
  - o_mem_full=1 from the next cycle.
- In IDLE and FULL, i_valid is ignored. There are no writes and the RAM is frozen.
- Back-to-back i_valid every cycle is supported. DEPTH consecutive strobes fill the memory in exactly DEPTH cycles.
- Read port:
  - Independent of the write port (simple dual-port RAM).
  - When i_read_log=1 at a posedge, o_data_log<=RAM[i_addr_log]. Latency is 1 cycle.
  - When i_read_log=0, o_data_log holds its last value.
- Reads are legal in every state.
- A read of the address being written in the same cycle returns the old contents (read-first).
- A read during CAPTURE of an address not yet written returns stale data. This is not an error.
- i_run_log is expected to be one cycle wide. If held high, capture stays restarted at address 0 and nothing is written.
- reset mid-capture aborts immediately to IDLE with o_mem_full=0. Partial data stays in RAM.
- wr_ptr is NB_ADDR bits. Overflow never occurs outside the controlled wrap at DEPTH-1.

Decomposition:
- Package log_mem_pkg holds:
  - the state encoding (IDLE=2'd0, CAPTURE=2'd1, FULL=2'd2);
  - default NB_DATA/NB_ADDR constants, shared with the command register.
- One sub-module, log_bram:
  - simple dual-port, one write port and one registered read port with enable, read-first;
  - written for block-RAM inference.
- The FSM and pointer stay in log_memory_ctrl.

Test Plan:
1. Fill (NB_ADDR=4, DEPTH=16). Reset, pulse i_run_log, then 16 consecutive i_valid with i_data=0xA000+n. Required:
   - o_capturing=1 during the burst;
   - o_mem_full=1 exactly one cycle after the 16th strobe;
   - o_capturing=0 after that.
2. Readback. After scenario 1, i_read_log=1 sweeping addr 0..15. Required: o_data_log=0xA000+addr one cycle after each address. With i_read_log=0, output holds 0xA00F.
3. Frozen and simultaneous run. After full, drive 5 i_valid with 0xDEAD, read addr 3.
   - Required: 0xA003 (FULL ignores writes).
   - Then assert i_run_log together with i_valid=1, data 0xBEEF. Required: o_mem_full=0 next cycle; addr 0 still 0xA000, since that sample is discarded.
4. Gapped strobes. Run, then 16 strobes spaced by random 0-3 idle cycles, data 0xB000+n. Required: full only after the 16th strobe; readback 0xB000+addr.
5. Reset mid-capture. Run, 7 strobes of 0xC000+n, then assert reset. Required:
   - o_capturing=0, o_mem_full=0, o_data_log=0.
   - Subsequent i_valid writes nothing: reads give addr 0..6=0xC000+n, addr 7..15 unchanged from the previous fill.
6. Read-during-write. In CAPTURE, read addr k in the same cycle k is written. Required: old value returned; the new value is returned on the next read of k.
